// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranger.
// FSM encoding, centimetre conversion constant and tick helper.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_DONE      = 3'd4,
        ST_TOUT      = 3'd5,
        ST_HOLD      = 3'd6
    } state_e;

    // Round-trip sound time per centimetre of range, in microseconds.
    localparam int unsigned US_PER_CM = 58;

    // Clocks per microsecond, never less than one.
    function automatic int unsigned to_ticks(input int unsigned clk_hz);
        int unsigned t;
        t = clk_hz / 32'd1_000_000;
        return (t == 0) ? 32'd1 : t;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running 1 us prescaler.
// Emits a single-clock tick every CLK_HZ/1e6 clocks.
module us_tick_gen
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned DIV = to_ticks(CLK_HZ);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    // Divide the clock and pulse on each wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/ultrasonic_ranger_multi.sv
// Round-robin HC-SR04 ranging engine for N_CH sensors.
// Measures echo width in us and converts to cm by counting 58 us slices.
module ultrasonic_ranger_multi
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DIST_W     = 12,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 30000,
    parameter int unsigned PERIOD_US  = 60000,
    parameter int unsigned MAX_CM     = 400
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic [N_CH-1:0]                        echo,
    output logic [N_CH-1:0]                        trig,
    output logic [N_CH*DIST_W-1:0]                 distance,
    output logic [N_CH-1:0]                        dist_valid,
    output logic [N_CH-1:0]                        timeout_err,
    output logic [(N_CH>1?$clog2(N_CH):1)-1:0]     cur_ch,
    output logic                                   busy
);

    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TMR_MAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned PER_W   = $clog2(PERIOD_US + 1);
    localparam int unsigned CM_W    = $clog2(MAX_CM + 1);
    localparam int unsigned SUB_W   = $clog2(US_PER_CM);

    logic us_tick;

    us_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (us_tick)
    );

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    for (genvar k = 0; k < N_CH; k++) begin : g_sync
        // sh_q[1:0] is the synchroniser, sh_q[2] the previous sample.
        logic [2:0] sh_q;

        // Shift the raw echo pin through sync and edge stages.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sh_q <= '0;
            else          sh_q <= {sh_q[1:0], echo[k]};
        end

        assign rise[k] = sh_q[1] & ~sh_q[2];
        assign fall[k] = ~sh_q[1] & sh_q[2];
    end

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [CM_W-1:0]   cm_q, cm_d;
    logic [N_CH-1:0]   trig_q, trig_d;
    logic [N_CH*DIST_W-1:0] dist_q;
    logic [N_CH-1:0]   dv_q;
    logic [N_CH-1:0]   tout_q;

    logic rise_sel;
    logic fall_sel;
    logic tmr_exp;
    logic load_done;
    logic set_tout;

    assign rise_sel = rise[ch_q];
    assign fall_sel = fall[ch_q];
    assign tmr_exp  = (tmr_q >= TMR_W'(TIMEOUT_US));

    // Next-state, timer and measurement counter logic.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tmr_d   = tmr_q;
        per_d   = per_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        if (us_tick && state_q != ST_IDLE && per_q != PER_W'(PERIOD_US))
            per_d = per_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_TRIG;
                    tmr_d   = '0;
                    per_d   = '0;
                end
            end
            ST_TRIG: begin
                if (us_tick) tmr_d = tmr_q + 1'b1;
                if (tmr_q >= TMR_W'(TRIG_US)) begin
                    state_d = ST_WAIT_RISE;
                    tmr_d   = '0;
                    sub_d   = '0;
                    cm_d    = '0;
                end
            end
            ST_WAIT_RISE: begin
                if (us_tick) tmr_d = tmr_q + 1'b1;
                if (rise_sel)     state_d = ST_MEASURE;
                else if (tmr_exp) state_d = ST_TOUT;
            end
            ST_MEASURE: begin
                if (us_tick) begin
                    tmr_d = tmr_q + 1'b1;
                    if (sub_q == SUB_W'(US_PER_CM - 1)) begin
                        sub_d = '0;
                        if (cm_q < CM_W'(MAX_CM)) cm_d = cm_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                if (fall_sel)     state_d = ST_DONE;
                else if (tmr_exp) state_d = ST_TOUT;
            end
            ST_DONE: state_d = ST_HOLD;
            ST_TOUT: state_d = ST_HOLD;
            ST_HOLD: begin
                if (per_q >= PER_W'(PERIOD_US)) begin
                    ch_d = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
                    if (enable) begin
                        state_d = ST_TRIG;
                        tmr_d   = '0;
                        per_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Trigger pin pattern for the upcoming state.
    always_comb begin
        trig_d = '0;
        if (state_d == ST_TRIG) trig_d[ch_d] = 1'b1;
    end

    assign load_done = (state_q == ST_MEASURE) && (state_d == ST_DONE);
    assign set_tout  = (state_q != ST_TOUT) && (state_d == ST_TOUT);

    // FSM, counters and trigger register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            tmr_q   <= '0;
            per_q   <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            tmr_q   <= tmr_d;
            per_q   <= per_d;
            sub_q   <= sub_d;
            cm_q    <= cm_d;
            trig_q  <= trig_d;
        end
    end

    // Per-channel results; the final tick of the echo is included in cm_d.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dist_q <= '0;
            dv_q   <= '0;
            tout_q <= '0;
        end else begin
            dv_q <= '0;
            if (load_done) begin
                dist_q[ch_q*DIST_W +: DIST_W] <= DIST_W'(cm_d);
                dv_q[ch_q]   <= 1'b1;
                tout_q[ch_q] <= 1'b0;
            end
            if (set_tout) tout_q[ch_q] <= 1'b1;
        end
    end

    assign trig        = trig_q;
    assign distance    = dist_q;
    assign dist_valid  = dv_q;
    assign timeout_err = tout_q;
    assign cur_ch      = ch_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger_multi.sv
// Directed bench for ultrasonic_ranger_multi.
// 2 MHz clock keeps the 2 ms scan slots short in clock cycles.
`timescale 1ns/1ps
module tb_ultrasonic_ranger_multi;

    localparam int NCH = 4;
    localparam int DW  = 12;
    localparam int CPU = 2;

    typedef struct {
        int ch;
        int len;
        int other;
        bit drop;
        int exp_d;
        int exp_dv;
        int exp_to;
    } row_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic [NCH-1:0] echo = '0;
    logic [NCH-1:0] trig;
    logic [NCH*DW-1:0] distance;
    logic [NCH-1:0] dist_valid;
    logic [NCH-1:0] timeout_err;
    logic [1:0] cur_ch;
    logic busy;

    ultrasonic_ranger_multi #(
        .CLK_HZ     (2_000_000),
        .N_CH       (NCH),
        .DIST_W     (DW),
        .TRIG_US    (10),
        .TIMEOUT_US (1500),
        .PERIOD_US  (2000),
        .MAX_CM     (20)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .echo        (echo),
        .trig        (trig),
        .distance    (distance),
        .dist_valid  (dist_valid),
        .timeout_err (timeout_err),
        .cur_ch      (cur_ch),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int dv_cnt [NCH];
    int onehot_bad = 0;
    logic [NCH-1:0] trig_prev = '0;
    longint tr_t[$];
    int tr_ch[$];
    row_t rows [7];

    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (dist_valid[k]) dv_cnt[k]++;
            if (trig[k] && !trig_prev[k]) begin
                tr_ch.push_back(k);
                tr_t.push_back(longint'($time));
            end
        end
        if ($countones(trig) > 1) onehot_bad++;
        trig_prev = trig;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int dist_of(input int ch);
        return int'(distance[ch*DW +: DW]);
    endfunction

    task automatic wait_trig(input int ch, input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (trig[ch] == lvl) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic run_row(input int idx, input row_t r);
        bit ok;
        int d0;
        wait_trig(r.ch, 1'b1, ok);
        chk($sformatf("r%0d_trig_rise", idx), ok, 1);
        wait_trig(r.ch, 1'b0, ok);
        chk($sformatf("r%0d_trig_fall", idx), ok, 1);
        d0 = dv_cnt[r.ch];
        step(CPU * 20);
        if (r.len > 0) begin
            echo[r.ch] = 1'b1;
            if (r.drop) enable = 1'b0;
            step(CPU * r.len);
            echo[r.ch] = 1'b0;
            step(2);
            chk($sformatf("r%0d_dv_lat2", idx), dist_valid[r.ch], 0);
            step(1);
            chk($sformatf("r%0d_dv_lat3", idx), dist_valid[r.ch], 1);
        end else begin
            echo[r.other] = 1'b1;
            step(CPU * 300);
            echo[r.other] = 1'b0;
            step(CPU * 1080);
            chk($sformatf("r%0d_tout_early", idx), timeout_err[r.ch], 0);
            step(CPU * 200);
            chk($sformatf("r%0d_tout_late", idx), timeout_err[r.ch], 1);
        end
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (cur_ch != 2'(r.ch) || !busy) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        chk($sformatf("r%0d_slot_end", idx), ok, 1);
        chk($sformatf("r%0d_dist", idx), dist_of(r.ch), r.exp_d);
        chk($sformatf("r%0d_dv_count", idx), dv_cnt[r.ch] - d0, r.exp_dv);
        chk($sformatf("r%0d_tout", idx), timeout_err[r.ch], r.exp_to);
    endtask

    initial begin
        bit ok;
        int d0;
        rows[0] = '{ch: 0, len: 580,  other: 0, drop: 0, exp_d: 10, exp_dv: 1, exp_to: 0};
        rows[1] = '{ch: 1, len: 0,    other: 2, drop: 0, exp_d: 0,  exp_dv: 0, exp_to: 1};
        rows[2] = '{ch: 2, len: 1160, other: 0, drop: 0, exp_d: 20, exp_dv: 1, exp_to: 0};
        rows[3] = '{ch: 3, len: 1400, other: 0, drop: 0, exp_d: 20, exp_dv: 1, exp_to: 0};
        rows[4] = '{ch: 0, len: 57,   other: 0, drop: 0, exp_d: 0,  exp_dv: 1, exp_to: 0};
        rows[5] = '{ch: 1, len: 59,   other: 0, drop: 0, exp_d: 1,  exp_dv: 1, exp_to: 0};
        rows[6] = '{ch: 2, len: 300,  other: 0, drop: 1, exp_d: 5,  exp_dv: 1, exp_to: 0};
        for (int k = 0; k < NCH; k++) dv_cnt[k] = 0;

        step(4);
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_ch", cur_ch, 0);
        chk("rst_distance", distance, 0);
        chk("rst_dv", dist_valid, 0);
        chk("rst_tout", timeout_err, 0);
        reset_n = 1'b1;
        step(3);
        chk("idle_busy", busy, 0);
        enable = 1'b1;

        for (int i = 0; i < 7; i++) run_row(i, rows[i]);

        chk("drop_busy", busy, 0);
        chk("drop_cur_ch", cur_ch, 3);
        step(CPU * 300);
        chk("drop_busy_late", busy, 0);
        chk("n_trig", tr_ch.size(), 7);
        for (int i = 0; i < tr_ch.size() && i < 7; i++)
            chk($sformatf("trig_order%0d", i), tr_ch[i], i % NCH);
        for (int i = 2; i < tr_t.size() && i < 7; i++)
            chk($sformatf("trig_gap%0d", i), tr_t[i] - tr_t[i-1], 40000);
        chk("trig_onehot", onehot_bad, 0);

        enable = 1'b1;
        wait_trig(3, 1'b1, ok);
        chk("b_trig3_rise", ok, 1);
        step(4);
        reset_n = 1'b0;
        #1;
        chk("b_trig_drop", trig, 0);
        chk("b_cur_ch0", cur_ch, 0);
        step(2);
        reset_n = 1'b1;
        wait_trig(0, 1'b1, ok);
        chk("b_trig0_rise", ok, 1);
        wait_trig(0, 1'b0, ok);
        chk("b_trig0_fall", ok, 1);
        step(CPU * 20);
        echo[0] = 1'b1;
        step(CPU * 100);
        reset_n = 1'b0;
        #1;
        chk("m_trig", trig, 0);
        chk("m_busy", busy, 0);
        chk("m_cur_ch", cur_ch, 0);
        chk("m_distance", distance, 0);
        chk("m_dv", dist_valid, 0);
        chk("m_tout", timeout_err, 0);
        step(4);
        d0 = dv_cnt[0];
        reset_n = 1'b1;
        wait_trig(0, 1'b1, ok);
        chk("h_trig_rise", ok, 1);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (cur_ch != 2'd0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        chk("h_slot_end", ok, 1);
        chk("h_tout", timeout_err[0], 1);
        chk("h_dv_count", dv_cnt[0] - d0, 0);
        chk("h_dist", dist_of(0), 0);
        enable = 1'b0;
        echo = '0;
        step(4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
